// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out shift-register chain drivers.
package piso_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  // Default chain geometry used by the board-level drivers
  localparam int PISO_DEF_DATA_W      = 8;
  localparam int PISO_DEF_DIV         = 2;
  localparam int PISO_DEF_LATCH_PULSE = 2;

  // Width of a counter that must reach n-1; never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_phase_timer.sv
// Half-period timer: counts clk cycles while enabled and flags the last
// cycle of each DIV-cycle phase. Restarted by the sequencer on acceptance.
module piso_phase_timer
  import piso_pkg::*;
#(
  parameter int DIV = PISO_DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic phase_end
);

  localparam int CNT_W = cnt_w(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  // Next count: wrap at the terminal value, park at zero when not shifting
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (restart) begin
      div_cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      if (div_cnt_q == LAST) begin
        div_cnt_d = {CNT_W{1'b0}};
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
    end else begin
      div_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= {CNT_W{1'b0}};
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign phase_end = en && (div_cnt_q == LAST);

endmodule

// File: rtl/piso_shift_driver.sv
// Parametrised driver for 74HC595-style chains: accepts a word over
// valid/ready, shifts it out with a generated shift clock, then pulses the
// storage latch and strobes done.
module piso_shift_driver
  import piso_pkg::*;
#(
  parameter int DATA_W      = PISO_DEF_DATA_W,
  parameter int DIV         = PISO_DEF_DIV,
  parameter int LATCH_PULSE = PISO_DEF_LATCH_PULSE,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              serial_out,
  output logic              shift_clk,
  output logic              latch_clk,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int LAT_W = cnt_w(LATCH_PULSE);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(LATCH_PULSE - 1);

  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   shadow_q,    shadow_d;
  logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q,   lat_cnt_d;
  logic                serial_q,    serial_d;
  logic                shift_clk_q, shift_clk_d;
  logic                latch_clk_q, latch_clk_d;
  logic                done_q,      done_d;

  logic                restart_s;
  logic                timer_en_s;
  logic                phase_end_s;

  assign timer_en_s = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

  piso_phase_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart_s),
    .en        (timer_en_s),
    .phase_end (phase_end_s)
  );

  // Sequencer next-state and next-output decode; data moves only on the
  // falling edge of shift_clk so the chain sees DIV cycles of setup and hold
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bit_cnt_d   = bit_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    serial_d    = serial_q;
    shift_clk_d = shift_clk_q;
    latch_clk_d = latch_clk_q;
    done_d      = 1'b0;
    restart_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d     = SHIFT_LO;
          shadow_d    = load_data;
          bit_cnt_d   = {BIT_W{1'b0}};
          restart_s   = 1'b1;
          shift_clk_d = 1'b0;
          if (MSB_FIRST) begin
            serial_d = load_data[DATA_W-1];
          end else begin
            serial_d = load_data[0];
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT_LO: begin
        if (phase_end_s) begin
          state_d     = SHIFT_HI;
          shift_clk_d = 1'b1;
        end else begin
          state_d = SHIFT_LO;
        end
      end

      SHIFT_HI: begin
        if (phase_end_s) begin
          shift_clk_d = 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d     = LATCH;
            latch_clk_d = 1'b1;
            lat_cnt_d   = {LAT_W{1'b0}};
          end else begin
            state_d   = SHIFT_LO;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            // The shadow is shifted so the next bit always sits next to the exit end
            if (MSB_FIRST) begin
              serial_d = shadow_q[DATA_W-2];
              shadow_d = {shadow_q[DATA_W-2:0], 1'b0};
            end else begin
              serial_d = shadow_q[1];
              shadow_d = {1'b0, shadow_q[DATA_W-1:1]};
            end
          end
        end else begin
          state_d = SHIFT_HI;
        end
      end

      LATCH: begin
        if (lat_cnt_q == LAST_LAT) begin
          state_d     = IDLE;
          latch_clk_d = 1'b0;
          done_d      = 1'b1;
          serial_d    = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        serial_d    = 1'b0;
        shift_clk_d = 1'b0;
        latch_clk_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a latch pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shadow_q    <= {DATA_W{1'b0}};
      bit_cnt_q   <= {BIT_W{1'b0}};
      lat_cnt_q   <= {LAT_W{1'b0}};
      serial_q    <= 1'b0;
      shift_clk_q <= 1'b0;
      latch_clk_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      serial_q    <= serial_d;
      shift_clk_q <= shift_clk_d;
      latch_clk_q <= latch_clk_d;
      done_q      <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = !load_ready;
  assign serial_out = serial_q;
  assign shift_clk  = shift_clk_q;
  assign latch_clk  = latch_clk_q;
  assign done       = done_q;

endmodule
